// File: rtl/dmem_pkg.sv
// Shared constants and types for the dmem_lsu data-memory load/store unit.
package dmem_pkg;

  localparam int LAT_CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the MEM stage (master) and dmem_lsu (slave).
interface dmem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables/shifted data, load extract/extend,
// and misalignment / illegal-funct3 detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_data,
  output logic        err
);

  logic        illegal;
  logic        misaligned;
  logic [15:0] rhalf;

  assign rhalf = 16'(rword >> {lane, 3'b000});

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    be         = '0;
    wdata_sh   = '0;
    load_data  = '0;
    illegal    = we ? (funct3 > F3_W) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = 1'b0;

    unique case (funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    err = illegal | misaligned;

    unique case (funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << lane;
        wdata_sh = {4{wdata[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << {lane[1], 1'b0};
        wdata_sh = {2{wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata_sh = wdata;
      end
    endcase
    if (!we || err) be = '0;

    unique case (funct3)
      F3_B:    load_data = {{24{rhalf[7]}}, rhalf[7:0]};
      F3_BU:   load_data = {24'h0, rhalf[7:0]};
      F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_data = {16'h0, rhalf};
      default: load_data = rword;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable little-endian data store behind a valid/ready handshake,
// one request in flight, LAT cycles accept-to-response. Macro DMEM_ACCESS_FAULT_EN faults high addresses.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LAT    = 1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int                   DEPTH    = 2 ** (ADDR_W - 2);
  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LAT - 1);

  state_e               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [2:0]           f3_q, f3_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic              accept, access;
  logic              op_we;
  logic [2:0]        op_f3;
  logic [31:0]       op_addr, op_wdata;
  logic [ADDR_W-3:0] op_idx;
  logic [3:0]        be;
  logic [31:0]       wdata_sh, load_data;
  logic              align_err, hi_fault, op_err;

  assign accept = bus.req_valid && (state_q == IDLE);

  // In IDLE the live request drives the datapath so LAT=1 commits on the accept edge itself.
  assign op_we    = (state_q == IDLE) ? bus.req_we     : we_q;
  assign op_f3    = (state_q == IDLE) ? bus.req_funct3 : f3_q;
  assign op_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
  assign op_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
  assign op_idx   = op_addr[ADDR_W-1:2];

`ifdef DMEM_ACCESS_FAULT_EN
  assign hi_fault = |op_addr[31:ADDR_W];
`else
  logic unused_addr_hi;
  assign hi_fault       = 1'b0;
  assign unused_addr_hi = ^op_addr[31:ADDR_W];
`endif

  assign op_err = align_err | hi_fault;

  dmem_lane_align u_align (
    .we        (op_we),
    .funct3    (op_f3),
    .lane      (op_addr[1:0]),
    .wdata     (op_wdata),
    .rword     (mem[op_idx]),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .load_data (load_data),
    .err       (align_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (CNT_INIT == '0) ? RESP : WAIT;
      WAIT:    if (cnt_q == LAT_CNT_W'(1)) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign access = (state_q != RESP) && (state_d == RESP);

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    if (accept) begin
      cnt_d   = CNT_INIT;
      we_d    = bus.req_we;
      f3_d    = bus.req_funct3;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end

    if (access) begin
      err_d   = op_err;
      rdata_d = (op_we || op_err) ? '0 : load_data;
    end else if (state_q == RESP && bus.rsp_ready) begin
      err_d   = 1'b0;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array is deliberately not reset; it would defeat RAM inference and contents must survive rst.
  always_ff @(posedge clk) begin
    if (!rst && access && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[op_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: LAT=1 and LAT=4 instances share one request stream,
// expected responses come from a byte-array reference model.
module tb_dmem_lsu;
  import dmem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   bp_mode = 0;
  int   stall_cnt [2];

  logic [7:0] ref_mem [65536];
  exp_t       exp_q [2][$];
  int         acc_q [2][$];
  bit         in_rsp [2];
  exp_t       cur [2];

  dmem_lsu_if if1 ();
  dmem_lsu_if if4 ();

  dmem_lsu #(.ADDR_W(16), .LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  dmem_lsu #(.ADDR_W(16), .LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output exp_t e);
    int          size;
    bit          legal, sgn, err;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    sgn   = (f3[2] == 1'b0);
    err   = !legal || ((a % 32'(size)) != 0);
`ifdef DMEM_ACCESS_FAULT_EN
    if (a >= 32'h0001_0000) err = 1'b1;
`endif
    e.err   = err;
    e.rdata = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[16'(a + 32'(i))] = 8'(wd >> (8 * i));
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[16'(a + 32'(i))]) << (8 * i));
        if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
        e.rdata = v;
      end
    end
  endfunction

  task automatic mon_step(input int id, input logic rv, input logic rr, input logic [31:0] rd,
                          input logic er, input logic qv, input logic qr);
    int lat;
    int a;
    lat = (id == 0) ? 1 : 4;
    if (rst) begin
      exp_q[id].delete();
      acc_q[id].delete();
      in_rsp[id] = 1'b0;
      return;
    end
    if (qv && qr) acc_q[id].push_back(cyc);
    if (rv) begin
      if (!in_rsp[id]) begin
        if (exp_q[id].size() == 0 || acc_q[id].size() == 0) begin
          check($sformatf("dut%0d_spurious_rsp", id), 32'd1, 32'd0);
        end else begin
          cur[id] = exp_q[id].pop_front();
          a       = acc_q[id].pop_front();
          check($sformatf("dut%0d_latency", id), 32'(cyc - a), 32'(lat));
          check($sformatf("dut%0d_rdata", id), rd, cur[id].rdata);
          check($sformatf("dut%0d_err", id), 32'(er), 32'(cur[id].err));
        end
        in_rsp[id] = 1'b1;
      end else begin
        check($sformatf("dut%0d_hold_rdata", id), rd, cur[id].rdata);
        check($sformatf("dut%0d_hold_err", id), 32'(er), 32'(cur[id].err));
      end
      if (rr) in_rsp[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, if1.rsp_valid, if1.rsp_ready, if1.rsp_rdata, if1.rsp_err, if1.req_valid, if1.req_ready);
    mon_step(1, if4.rsp_valid, if4.rsp_ready, if4.rsp_rdata, if4.rsp_err, if4.req_valid, if4.req_ready);
  end

  function automatic logic rr_val(input logic rv, inout int st);
    if (bp_mode == 0) return 1'b1;
    if (bp_mode == 1) return 1'($urandom_range(0, 1));
    if (!rv) begin
      st = 0;
      return 1'b0;
    end
    st++;
    return (st > 3);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if1.rsp_ready = rr_val(if1.rsp_valid, stall_cnt[0]);
      if4.rsp_ready = rr_val(if4.rsp_valid, stall_cnt[1]);
    end
  end

  task automatic set_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    if1.req_we = we; if1.req_funct3 = f3; if1.req_addr = a; if1.req_wdata = wd;
    if4.req_we = we; if4.req_funct3 = f3; if4.req_addr = a; if4.req_wdata = wd;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(if1.req_ready && if4.req_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    exp_t e;
    wait_idle();
    model(we, f3, a, wd, e);
    exp_q[0].push_back(e);
    exp_q[1].push_back(e);
    set_req(we, f3, a, wd);
    if1.req_valid = 1'b1;
    if4.req_valid = 1'b1;
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    if (hold) begin
      for (int i = 0; i < 2; i++) begin
        check("busy_req_ready", 32'(if4.req_ready), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    if4.req_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready1"}, 32'(if1.req_ready), 32'd1);
    check({tag, "_valid1"}, 32'(if1.rsp_valid), 32'd0);
    check({tag, "_rdata1"}, if1.rsp_rdata, 32'd0);
    check({tag, "_err1"},   32'(if1.rsp_err), 32'd0);
    check({tag, "_ready4"}, 32'(if4.req_ready), 32'd1);
    check({tag, "_valid4"}, 32'(if4.rsp_valid), 32'd0);
    check({tag, "_rdata4"}, if4.rsp_rdata, 32'd0);
    check({tag, "_err4"},   32'(if4.rsp_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    if1.req_valid = 1'b0; if4.req_valid = 1'b0;
    if1.rsp_ready = 1'b0; if4.rsp_ready = 1'b0;
    set_req(1'b0, F3_W, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("post_reset");

    issue(1'b1, F3_W,  32'h100, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, F3_W,  32'h100, 32'h0, 1'b0);
    issue(1'b1, F3_W,  32'h100, 32'h0, 1'b0);
    issue(1'b1, F3_B,  32'h101, 32'h0000_0080, 1'b0);
    issue(1'b0, F3_B,  32'h101, 32'h0, 1'b0);
    issue(1'b0, F3_BU, 32'h101, 32'h0, 1'b0);
    issue(1'b0, F3_W,  32'h100, 32'h0, 1'b0);
    issue(1'b1, F3_H,  32'h202, 32'h0000_1234, 1'b0);
    issue(1'b0, F3_HU, 32'h202, 32'h0, 1'b0);
    issue(1'b0, F3_W,  32'h203, 32'h0, 1'b0);
    issue(1'b0, F3_W,  32'h200, 32'h0, 1'b0);
    issue(1'b1, F3_H,  32'h201, 32'h0000_BEEF, 1'b0);
    issue(1'b0, F3_W,  32'h200, 32'h0, 1'b0);
    issue(1'b1, 3'b011, 32'h204, 32'h1, 1'b0);
    issue(1'b0, 3'b110, 32'h204, 32'h0, 1'b0);

    bp_mode = 2;
    issue(1'b1, F3_W, 32'h300, 32'h0BAD_F00D, 1'b0);
    issue(1'b0, F3_W, 32'h300, 32'h0, 1'b1);
    bp_mode = 0;

    issue(1'b1, F3_W, 32'h0001_0000, 32'h0000_0011, 1'b0);
    issue(1'b0, F3_W, 32'h0000_0000, 32'h0, 1'b0);

    wait_idle();
    set_req(1'b1, F3_W, 32'h40, 32'h0000_00AA);
    if4.req_valid = 1'b1;
    @(posedge clk);
    #1;
    if4.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_ready4", 32'(if4.req_ready), 32'd1);
    issue(1'b0, F3_W, 32'h40, 32'h0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      bp_mode = $urandom_range(0, 1);
      a  = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
      f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), f3, a, $urandom, 1'($urandom_range(0, 1)));
    end

    bp_mode = 0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("drain_dut1", 32'(exp_q[0].size()), 32'd0);
    check("drain_dut4", 32'(exp_q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
